// File: rtl/fast_nms_stream.sv
// -----------------------------------------------------------------------------
// fast_nms_stream
//
// Streaming non-maximum suppression for FAST keypoint scores. Pixels arrive in
// raster order as {flag, score}; a WIN x WIN window slides over the image and
// the window centre survives only if it is a keypoint whose score dominates
// every neighbour. Surviving keypoints are emitted as their flag value and
// counted per frame.
//
// Pipeline:
//   stage 1 (on i_image_en) : line buffers and window shift registers advance,
//                             position and frame-valid of the pixel are captured
//   stage 2                 : window centre is evaluated and registered
// The result for input pixel (row, col) describes image pixel (row-HALF,
// col-HALF) and appears on the outputs 2 cycles after the pixel is accepted,
// aligned with the 2-cycle delayed sync signals.
//
// Parameters:
//   WIN       square window size, 3, 5 or 7 (HALF = WIN/2)
//   IMG_WIDTH active pixels per line
//   SCORE_W   score field width
//   FLAG_W    flag field width (flag == 0 means "not a keypoint"), FLAG_W <= 8
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_image_vs            frame sync, rising edge starts a frame
//   i_image_hs            line sync, passed through
//   i_image_en            pixel valid
//   i_image_data          {flag, score}
//   o_image_vs/hs/en      input syncs delayed by 2 cycles
//   o_image_data          {zeros, flag} for a surviving centre, else 0
//   o_kp_count            keypoint count of the last completed frame
//   o_kp_count_vld        one-cycle pulse when o_kp_count updates
//
// Build option:
//   FAST_NMS_STRICT_TIE_EN  when defined, ties are broken in raster order: the
//                           centre must beat earlier neighbours strictly and
//                           only match later ones, so a flat plateau yields a
//                           single keypoint. Undefined: centre must be >= all
//                           neighbours, so plateaus yield several keypoints.
// -----------------------------------------------------------------------------
module fast_nms_stream #(
  parameter int WIN       = 7,
  parameter int IMG_WIDTH = 640,
  parameter int SCORE_W   = 14,
  parameter int FLAG_W    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_image_vs,
  input  logic                      i_image_hs,
  input  logic                      i_image_en,
  input  logic [FLAG_W+SCORE_W-1:0] i_image_data,
  output logic                      o_image_vs,
  output logic                      o_image_hs,
  output logic                      o_image_en,
  output logic [7:0]                o_image_data,
  output logic [15:0]               o_kp_count,
  output logic                      o_kp_count_vld
);

  localparam int HALF  = WIN / 2;
  localparam int DW    = FLAG_W + SCORE_W;
  localparam int NLB   = 2 * HALF;  // number of stored previous lines
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(NLB);
  localparam logic [15:0]      ROW_MIN  = 16'(NLB);

  // ---------------------------------------------------------------------------
  // Sync delay line. The first stage doubles as the previous-vs sample used
  // for frame-start edge detection.
  // ---------------------------------------------------------------------------
  logic vs_d1_q;
  logic hs_d1_q;
  logic en_d1_q;
  logic vs_rise;

  assign vs_rise = i_image_vs & ~vs_d1_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vs_d1_q    <= 1'b0;
      hs_d1_q    <= 1'b0;
      en_d1_q    <= 1'b0;
      o_image_vs <= 1'b0;
      o_image_hs <= 1'b0;
      o_image_en <= 1'b0;
    end else begin
      vs_d1_q    <= i_image_vs;
      hs_d1_q    <= i_image_hs;
      en_d1_q    <= i_image_en;
      o_image_vs <= vs_d1_q;
      o_image_hs <= hs_d1_q;
      o_image_en <= en_d1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel position and frame-valid tracking.
  // A vs rising edge restarts the position in the same cycle, so a pixel that
  // coincides with the edge is treated as (0, 0) of the new frame.
  // frame_ok stays low after a reset until a frame start is seen, which keeps
  // a frame interrupted by reset from producing misaligned results.
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] col_q, col_cur, col_d;
  logic [15:0]      row_q, row_cur, row_d;
  logic             frame_ok_q, frame_ok_cur;

  // NOTE: every combinational output gets a default at the top of the block,
  // so no path through the block can leave a value held (no latch).
  always_comb begin
    col_cur      = vs_rise ? '0 : col_q;
    row_cur      = vs_rise ? '0 : row_q;
    frame_ok_cur = vs_rise | frame_ok_q;
    col_d        = col_cur;
    row_d        = row_cur;
    if (i_image_en) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        if (row_cur != 16'hFFFF) begin
          row_d = row_cur + 16'd1;
        end
      end else begin
        col_d = col_cur + COL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_q      <= '0;
      row_q      <= '0;
      frame_ok_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      frame_ok_q <= frame_ok_cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers. One word per column packs the previous NLB lines:
  // slot j (bits [j*DW +: DW]) holds line row-1-j. Writing shifts every slot up
  // by one and puts the incoming pixel into slot 0.
  // ---------------------------------------------------------------------------
  logic [NLB*DW-1:0] lb_mem [IMG_WIDTH];
  logic [NLB*DW-1:0] lb_rd;
  logic [NLB*DW-1:0] lb_wr;

  assign lb_rd = lb_mem[col_cur];
  assign lb_wr = {lb_rd[(NLB-1)*DW-1:0], i_image_data};

  // NOTE: the line memory has no reset; stale contents only ever reach the
  // window while the border mask forces the output to zero.
  always_ff @(posedge i_clk) begin
    if (i_image_en) begin
      lb_mem[col_cur] <= lb_wr;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: window shift registers.
  // win_q[r][c]: r = 0 is the oldest line (row-2*HALF), c = WIN-1 the newest
  // column. The incoming column is assembled from the line buffer slots plus
  // the live pixel at the bottom.
  // ---------------------------------------------------------------------------
  logic [DW-1:0]    win_q [WIN][WIN];
  logic [DW-1:0]    new_col [WIN];
  logic [15:0]      row_s1_q;
  logic [COL_W-1:0] col_s1_q;
  logic             ok_s1_q;

  always_comb begin
    for (int r = 0; r < NLB; r++) begin
      new_col[r] = lb_rd[(NLB-1-r)*DW +: DW];
    end
    new_col[NLB] = i_image_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          win_q[r][c] <= '0;
        end
      end
      row_s1_q <= '0;
      col_s1_q <= '0;
      ok_s1_q  <= 1'b0;
    end else if (i_image_en) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN-1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][WIN-1] <= new_col[r];
      end
      row_s1_q <= row_cur;
      col_s1_q <= col_cur;
      ok_s1_q  <= frame_ok_cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: centre evaluation.
  // ---------------------------------------------------------------------------

  // A neighbour that is not a keypoint competes with score 0.
  function automatic logic [SCORE_W-1:0] eff_score(input logic [DW-1:0] px);
    return (px[DW-1:SCORE_W] != '0) ? px[SCORE_W-1:0] : '0;
  endfunction

  logic [FLAG_W-1:0]  c_flag;
  logic [SCORE_W-1:0] c_score;
  logic               nb_pass;
  logic               border;
  logic               survive;
  logic [7:0]         data_d;

  always_comb begin
    c_flag  = win_q[HALF][HALF][DW-1:SCORE_W];
    c_score = win_q[HALF][HALF][SCORE_W-1:0];
    nb_pass = 1'b1;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if (!(r == HALF && c == HALF)) begin
`ifdef FAST_NMS_STRICT_TIE_EN
          // Neighbours above, or left on the centre line, precede the centre
          // in raster order and must be beaten strictly.
          if ((r < HALF) || (r == HALF && c < HALF)) begin
            if (c_score <= eff_score(win_q[r][c])) begin
              nb_pass = 1'b0;
            end
          end else if (c_score < eff_score(win_q[r][c])) begin
            nb_pass = 1'b0;
          end
`else
          if (c_score < eff_score(win_q[r][c])) begin
            nb_pass = 1'b0;
          end
`endif
        end
      end
    end
    // Until 2*HALF lines and columns have been seen the window holds data from
    // the previous line or frame (or stale line buffer contents).
    border  = (row_s1_q < ROW_MIN) || (col_s1_q < COL_MIN);
    survive = ok_s1_q && !border && (c_flag != '0) && nb_pass;
    data_d  = survive ? 8'(c_flag) : 8'h00;
  end

  // The result register only moves when a pixel was accepted one cycle
  // earlier, so it is valid exactly while o_image_en is high and holds during
  // blanking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_image_data <= 8'h00;
    end else if (en_d1_q) begin
      o_image_data <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame keypoint counter. A surviving output that coincides with the
  // frame start still belongs to the frame being closed.
  // ---------------------------------------------------------------------------
  logic [15:0] kp_cnt_q;
  logic [15:0] kp_cnt_inc;
  logic        kp_event;

  assign kp_event   = o_image_en && (o_image_data != 8'h00);
  assign kp_cnt_inc = (kp_cnt_q == 16'hFFFF) ? kp_cnt_q : kp_cnt_q + 16'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      kp_cnt_q       <= '0;
      o_kp_count     <= '0;
      o_kp_count_vld <= 1'b0;
    end else begin
      o_kp_count_vld <= vs_rise;
      if (vs_rise) begin
        o_kp_count <= kp_event ? kp_cnt_inc : kp_cnt_q;
        kp_cnt_q   <= '0;
      end else if (kp_event) begin
        kp_cnt_q <= kp_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_fast_nms_stream.sv
// -----------------------------------------------------------------------------
// tb_fast_nms_stream
//
// Self-checking bench for fast_nms_stream with WIN=3, IMG_WIDTH=8 and 8-line
// frames. Each frame is a 2-D image array; expected outputs are derived from
// that image directly (image-coordinate NMS on the full frame) and queued in
// raster order, then compared with every o_image_en cycle. Syncs are compared
// against a 2-deep history of the driven values, frame counts at each vs edge.
// -----------------------------------------------------------------------------
module tb_fast_nms_stream;

  localparam int WIN     = 3;
  localparam int HALF    = WIN / 2;
  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int SCORE_W = 14;
  localparam int FLAG_W  = 2;
  localparam int DW      = FLAG_W + SCORE_W;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_image_vs = 1'b0;
  logic          i_image_hs = 1'b0;
  logic          i_image_en = 1'b0;
  logic [DW-1:0] i_image_data = '0;
  logic          o_image_vs;
  logic          o_image_hs;
  logic          o_image_en;
  logic [7:0]    o_image_data;
  logic [15:0]   o_kp_count;
  logic          o_kp_count_vld;

  always #5 i_clk = ~i_clk;

  fast_nms_stream #(
    .WIN      (WIN),
    .IMG_WIDTH(IMG_W),
    .SCORE_W  (SCORE_W),
    .FLAG_W   (FLAG_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_image_vs    (i_image_vs),
    .i_image_hs    (i_image_hs),
    .i_image_en    (i_image_en),
    .i_image_data  (i_image_data),
    .o_image_vs    (o_image_vs),
    .o_image_hs    (o_image_hs),
    .o_image_en    (o_image_en),
    .o_image_data  (o_image_data),
    .o_kp_count    (o_kp_count),
    .o_kp_count_vld(o_kp_count_vld)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] img [IMG_H][IMG_W];
  logic [7:0]    exp_q [$];
  int            exp_cnt  = 0;
  int            prev_cnt = 0;
  logic [1:0]    hist_vs  = '0;
  logic [1:0]    hist_hs  = '0;
  logic [1:0]    hist_en  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference: NMS at image pixel (r, c) evaluated on the whole frame.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] nms_ref(input int r, input int c);
    int cf;
    int cs;
    int nf;
    int ns;
    cf = int'(img[r][c][DW-1:SCORE_W]);
    cs = int'(img[r][c][SCORE_W-1:0]);
    if (cf == 0) return 8'h00;
    for (int dr = -HALF; dr <= HALF; dr++) begin
      for (int dc = -HALF; dc <= HALF; dc++) begin
        if (dr == 0 && dc == 0) continue;
        nf = int'(img[r+dr][c+dc][DW-1:SCORE_W]);
        ns = (nf == 0) ? 0 : int'(img[r+dr][c+dc][SCORE_W-1:0]);
`ifdef FAST_NMS_STRICT_TIE_EN
        if ((dr < 0 || (dr == 0 && dc < 0)) ? (cs <= ns) : (cs < ns)) return 8'h00;
`else
        if (cs < ns) return 8'h00;
`endif
      end
    end
    return 8'(cf);
  endfunction

  // One expected output per input pixel; only pixels whose centre lies at
  // least HALF away from the top/left edges can report a keypoint.
  task automatic build_expected();
    logic [7:0] e;
    exp_q.delete();
    exp_cnt = 0;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        e = (r >= 2*HALF && c >= 2*HALF) ? nms_ref(r - HALF, c - HALF) : 8'h00;
        exp_q.push_back(e);
        if (e != 8'h00) exp_cnt++;
      end
    end
  endtask

  task automatic clear_img();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = {2'b00, 14'($urandom)};
  endtask

  task automatic set_kp(input int r, input int c, input int flag, input int score);
    img[r][c] = {2'(flag), 14'(score)};
  endtask

  task automatic fill_random(input int pct, input int smax);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = {($urandom_range(99) < pct) ? 2'($urandom_range(3, 1)) : 2'b00,
                     14'($urandom_range(smax))};
  endtask

  // Drive one cycle, then sample #1 after the edge.
  task automatic step(input logic vs, input logic hs, input logic en, input logic [DW-1:0] d);
    i_image_vs   = vs;
    i_image_hs   = hs;
    i_image_en   = en;
    i_image_data = d;
    @(posedge i_clk);
    #1;
    if (i_rst) begin
      hist_vs = '0;
      hist_hs = '0;
      hist_en = '0;
    end else begin
      hist_vs = {hist_vs[0], vs};
      hist_hs = {hist_hs[0], hs};
      hist_en = {hist_en[0], en};
    end
    check("vs_delay", 32'(o_image_vs), 32'(hist_vs[1]));
    check("hs_delay", 32'(o_image_hs), 32'(hist_hs[1]));
    check("en_delay", 32'(o_image_en), 32'(hist_en[1]));
    if (o_image_en) begin
      if (exp_q.size() == 0) check("extra_output", 32'(exp_q.size()), 32'd1);
      else check("data", 32'(o_image_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic frame_start(input string name);
    step(1'b1, 1'b0, 1'b0, '0);
    check({name, "_cnt_vld"}, 32'(o_kp_count_vld), 32'd1);
    check({name, "_cnt"}, 32'(o_kp_count), 32'(prev_cnt));
    step(1'b0, 1'b0, 1'b0, '0);
    check({name, "_vld_pulse"}, 32'(o_kp_count_vld), 32'd0);
  endtask

  task automatic drive_rows(input int r0, input int r1, input int gap);
    for (int r = r0; r < r1; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        step(1'b0, 1'b1, 1'b1, img[r][c]);
        repeat (gap) step(1'b0, 1'b1, 1'b0, '0);
      end
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic run_frame(input int gap, input string name);
    frame_start(name);
    build_expected();
    drive_rows(0, IMG_H, gap);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    prev_cnt = exp_cnt;
  endtask

  initial begin
    // Reset state, checked before any clock edge.
    i_rst = 1'b1;
    #1;
    check("rst_vs",   32'(o_image_vs),     32'd0);
    check("rst_hs",   32'(o_image_hs),     32'd0);
    check("rst_en",   32'(o_image_en),     32'd0);
    check("rst_data", 32'(o_image_data),   32'd0);
    check("rst_cnt",  32'(o_kp_count),     32'd0);
    check("rst_vld",  32'(o_kp_count_vld), 32'd0);
    #20;
    i_rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, '0);

    // Isolated keypoint, gap-free and with 3-cycle blanking between pixels.
    clear_img();
    set_kp(4, 4, 1, 100);
    run_frame(0, "single");
    check("single_exp_cnt_model", 32'(exp_cnt), 32'd1);
    run_frame(3, "single_gap");

    // Two neighbours, the stronger one wins.
    clear_img();
    set_kp(3, 3, 1, 50);
    set_kp(3, 4, 2, 80);
    run_frame(0, "pair");

    // Equal plateau: tie handling depends on the build option.
    clear_img();
    set_kp(3, 3, 1, 60);
    set_kp(3, 4, 1, 60);
    run_frame(0, "plateau");

    // Keypoints only on the border.
    clear_img();
    set_kp(0, 0, 3, 900);
    set_kp(1, 7, 2, 900);
    run_frame(0, "border");

    // Random frames with small score range for frequent ties.
    fill_random(40, 7);
    run_frame(0, "rand_a");
    fill_random(60, 3);
    run_frame(3, "rand_b");

    // Mid-frame reset at row 4.
    clear_img();
    set_kp(2, 2, 1, 100);
    set_kp(4, 4, 1, 100);
    frame_start("pre_reset");
    build_expected();
    drive_rows(0, 4, 0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b1, img[4][c]);
    #2;
    i_rst = 1'b1;
    #1;
    check("midrst_en",   32'(o_image_en),     32'd0);
    check("midrst_data", 32'(o_image_data),   32'd0);
    check("midrst_cnt",  32'(o_kp_count),     32'd0);
    check("midrst_vld",  32'(o_kp_count_vld), 32'd0);
    exp_q.delete();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    i_rst = 1'b0;
    // The rest of the interrupted frame must produce only zero data.
    for (int i = 0; i < 4 + 3*IMG_W; i++) exp_q.push_back(8'h00);
    for (int c = 4; c < IMG_W; c++) step(1'b0, 1'b1, 1'b1, img[4][c]);
    drive_rows(5, IMG_H, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    check("midrst_drained", 32'(exp_q.size()), 32'd0);
    prev_cnt = 0;

    // Normal operation resumes at the next frame.
    fill_random(40, 7);
    set_kp(4, 4, 3, 5000);
    run_frame(0, "post_reset");

    frame_start("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fast_nms_stream.md
FAST_NMS_STREAM -- requirements
Module: fast_nms_stream

Interface
REQ-001 SHALL have parameter WIN, default 7, meaning the square NMS window size; legal values are 3, 5 and 7; HALF = WIN/2.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, meaning the active pixels per line.
REQ-003 SHALL have parameter SCORE_W, default 14, meaning the score field width.
REQ-004 SHALL have parameter FLAG_W, default 2, meaning the keypoint flag field width; DW = FLAG_W+SCORE_W.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_image_vs, input, 1 bit: frame sync; its rising edge starts a frame.
REQ-008 SHALL have port i_image_hs, input, 1 bit: line sync, passed through.
REQ-009 SHALL have port i_image_en, input, 1 bit: pixel valid.
REQ-010 SHALL have port i_image_data, input, DW bits: {flag[FLAG_W-1:0], score[SCORE_W-1:0]}; flag==0 means not a keypoint.
REQ-011 SHALL have ports o_image_vs, o_image_hs and o_image_en, output, 1 bit each: input syncs delayed by 2 cycles.
REQ-012 SHALL have port o_image_data, output, 8 bits: {zeros, flag} for a surviving keypoint, else 0.
REQ-013 SHALL have port o_kp_count, output, 16 bits: the keypoint count of the last completed frame.
REQ-014 SHALL have port o_kp_count_vld, output, 1 bit: a one-cycle pulse when o_kp_count updates.

Function
REQ-015 SHALL keep column counter col and row counter row; each i_image_en increments col; col wraps IMG_WIDTH-1 -> 0 and then increments row; both clear on the i_image_vs rising edge.
REQ-016 SHALL store the previous 2*HALF lines in internal line buffers (IMG_WIDTH x DW each), written only on i_image_en.
REQ-017 SHALL update the WIN x WIN window shift registers only on i_image_en (stage 1), so window and syncs advance together.
REQ-018 SHALL evaluate the window centre in stage 2: result for pixel (row-HALF, col-HALF), where (row, col) is the pixel accepted 2 cycles earlier.
REQ-019 SHALL treat a neighbour whose flag==0 as score 0 during comparison.
REQ-020 SHALL mark the centre as surviving only if centre flag!=0 AND it passes every neighbour comparison (REQ-032).
REQ-021 SHALL output o_image_data=0 when row<2*HALF or col<2*HALF (border, window incomplete).
REQ-022 SHALL never emit the bottom HALF rows and right HALF columns of the image as centres.
REQ-023 SHALL increment a frame counter for each o_image_en cycle with o_image_data!=0, saturating at 16'hFFFF.
REQ-024 SHALL, on the i_image_vs rising edge, copy the frame counter to o_kp_count, pulse o_kp_count_vld for 1 cycle, and clear the counter. On the first vs edge after reset it SHALL report 0.
REQ-025 SHALL, when a count event and a vs edge coincide, include the event in the latched value.
REQ-026 SHALL leave o_image_data, syncs and counters unchanged while i_image_en is low, with no window advance (blanking is tolerated).

Reset
REQ-027 SHALL, on i_rst high, immediately clear all outputs, col, row, window registers and the frame counter to 0, regardless of clock.
REQ-028 SHALL NOT require line buffer contents to be reset; border masking (REQ-021) hides stale data.
REQ-029 SHALL, when reset is asserted mid-frame, produce only zero data until the next vs rising edge, then resume normal operation.

Configuration
REQ-030 SHALL compile tie-breaking in when macro FAST_NMS_STRICT_TIE_EN is defined.
REQ-031 SHALL, with the macro defined, require the centre score to be strictly greater than neighbours earlier in raster order and >= neighbours later in raster order, so a plateau yields exactly one keypoint.
REQ-032 SHALL, without the macro, require the centre score to be >= all neighbours, so equal plateaus yield multiple keypoints.

Verification (WIN=3, IMG_WIDTH=8)
REQ-033 Single keypoint score 100 at (4,4), all else flag 0 -> exactly one o_image_data=8'h01 (flag 1), at the output for input (5,5); next vs edge gives o_kp_count=1.
REQ-034 Keypoints score 50 at (3,3) and score 80 at (3,4) -> only (3,4) survives; o_kp_count=1.
REQ-035 Equal scores 60 at (3,3) and (3,4) -> macro defined: only (3,3) survives, count 1; macro undefined: both survive, count 2.
REQ-036 Keypoint at (0,0) or (1,7) -> o_image_data stays 0 (border); o_kp_count=0.
REQ-037 i_rst pulsed at row 4 mid-frame -> all outputs 0 within the same cycle; data stays 0 until next vs; following frame output is correct.
REQ-038 Blanking gaps of 3 cycles inserted between every pixel -> results identical to the gap-free run; sync outputs stay 2-cycle delayed.
